pellet_eater: RTL and testbench
===============================

Name: pellet_eater

Overview:
- Client and controller for the pellet bitmap memory. Drives that memory's read/clear port B and its synchronous reset.
- On each player tile strobe it probes the tile. If a pellet is present it clears the pellet, adds points to the score and decrements the remaining count.
- On level start it reloads the map and counts the pellets by scanning all 1024 cells. Sits between player movement logic and the pellet memory, and feeds score and level-complete to game control.

Parameters:
POINTS, 10, score increment per pellet eaten
SCORE_W, 16, score width; score saturates at 2^SCORE_W-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
level_start  in  1  one-cycle pulse: reload map and recount
tile_valid  in  1  one-cycle pulse: player entered tile_x/tile_y
tile_x  in  5  player tile column
tile_y  in  5  player tile row
pel_out  in  1  pellet memory port-B read data (valid one cycle after address)
pel_x  out  5  pellet memory port-B column
pel_y  out  5  pellet memory port-B row
pel_clear  out  1  pellet memory port-B clear strobe
pel_reset  out  1  pellet memory synchronous reload, active-high
busy  out  1  high whenever state is not READY
eaten  out  1  one-cycle pulse per pellet consumed
score  out  SCORE_W  accumulated score
remaining  out  11  pellets left on map (0..1024)
level_clear  out  1  high while remaining==0 after a completed scan

Behaviour:
- States: RELOAD, SCAN, SCAN_TAIL, READY, PROBE, CHECK, CLEAR. All are registered.
- pel_x, pel_y, pel_clear and pel_reset are decoded from registers only, so they are glitch-free.
- Reset asserted: state=RELOAD, score=0, remaining=0, level_clear=0, eaten=0, scan addr=0.
  - Outputs during reset: busy=1, pel_reset=1, pel_clear=0, pel_x=pel_y=0.
  - Reset mid-operation aborts everything. After release the block runs RELOAD and then SCAN.
- RELOAD: pel_reset=1 for exactly one cycle, then go to SCAN with addr=0, remaining=0, level_clear=0.
- SCAN:
  - Each cycle drive pel_x=addr[4:0], pel_y=addr[9:5], pel_clear=0, then addr++.
  - From the second SCAN cycle on, add pel_out (the data for addr-1) to remaining.
  - After addr 1023 is issued, go to SCAN_TAIL.
- SCAN_TAIL: accumulate the last pel_out. Set level_clear if the final remaining==0. Go to READY.
- Scan duration: RELOAD 1 + SCAN 1024 + SCAN_TAIL 1 = 1026 cycles.
- READY: busy=0. A tile_valid pulse at cycle T latches tile_x/tile_y and the block goes to PROBE.
- PROBE (T+1): drive the latched address with pel_clear=0.
- CHECK (T+2): sample pel_out.
  - 1: go to CLEAR and register eaten=1.
  - 0: return to READY.
- CLEAR (T+3): drive the same address with pel_clear=1; eaten is high this cycle only.
  - score += POINTS, saturating at 2^SCORE_W-1.
  - remaining -= 1, never below 0.
  - New values are visible from T+4. level_clear rises at T+4 if remaining becomes 0.
  - Return to READY.
- tile_valid outside READY is dropped with no queueing. The player logic re-strobes.
- level_start in any state goes to RELOAD next cycle. It has priority over tile_valid and aborts a probe without clearing.
  - score is retained across levels; only reset clears it.
- Simultaneous level_start and tile_valid in READY: level_start wins.
- eaten never asserts during RELOAD, SCAN or SCAN_TAIL.

Decomposition:
- Shared package pellet_pkg holds:
  - state enum encoding
  - MAP_W=32, MAP_H=32, ADDR_W=10, REMAIN_W=11
  - default POINTS
  - the initial map image constant, shared with the pellet memory and the bench
- No sub-module: the scan counter and FSM fit in one module.

Test Plan:
- Release reset -> busy high for exactly 1026 cycles; pel_reset high in the first; remaining = popcount of the map image; level_clear=0.
- In READY, tile_valid at (2,2) -> eaten high at T+3 only; at T+4 score=10 and remaining=initial-1; pellet memory row 2 bit 2 reads 0.
- Repeat (2,2) -> no eaten; score stays 10; back in READY at T+3. Tile (0,0) -> no eaten.
- tile_valid while busy (during SCAN and PROBE) -> ignored, no eaten. level_start during PROBE -> no clear, full 1026-cycle rescan, remaining restored, score retained.
- Visit every set cell of the image -> remaining reaches 0 and level_clear rises on the cycle after the last eaten. level_start then drops level_clear.
- SCORE_W=8, POINTS=10: eat 26 pellets -> score saturates at 255 with no wrap.

Source files
------------

// File: rtl/pellet_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pellet_pkg: map geometry, FSM encoding and power-on pellet map image.  |
// | Rev 1.0  - initial release                                             |
// +------------------------------------------------------------------------+
package pellet_pkg;
  localparam int MAP_W          = 32;
  localparam int MAP_H          = 32;
  localparam int ADDR_W         = 10;
  localparam int COORD_W        = 5;
  localparam int REMAIN_W       = 11;
  localparam int POINTS_DEFAULT = 10;

  localparam logic [2:0] ST_RELOAD    = 3'd0;
  localparam logic [2:0] ST_SCAN      = 3'd1;
  localparam logic [2:0] ST_SCAN_TAIL = 3'd2;
  localparam logic [2:0] ST_READY     = 3'd3;
  localparam logic [2:0] ST_PROBE     = 3'd4;
  localparam logic [2:0] ST_CHECK     = 3'd5;
  localparam logic [2:0] ST_CLEAR     = 3'd6;

  // Cell (x,y) lives at bit y*MAP_W+x; pellets on even rows/columns except column 0.
  function automatic logic [MAP_W*MAP_H-1:0] build_map();
    logic [MAP_W*MAP_H-1:0] m;
    m = '0;
    for (int y = 0; y < MAP_H; y++) begin
      for (int x = 0; x < MAP_W; x++) begin
        if ((x % 2 == 0) && (y % 2 == 0) && (x != 0)) m[y*MAP_W+x] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [MAP_W*MAP_H-1:0] MAP_INIT = build_map();
endpackage
`default_nettype wire

// File: rtl/pellet_eater.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pellet_eater: probes/clears pellets on player tile strobes, keeps      |
// | score and remaining count, rescans the pellet map on level start.      |
// | Rev 1.0  - initial release                                             |
// +------------------------------------------------------------------------+
module pellet_eater
  import pellet_pkg::*;
#(
  parameter int POINTS  = POINTS_DEFAULT,
  parameter int SCORE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                level_start,
  input  logic                tile_valid,
  input  logic [COORD_W-1:0]  tile_x,
  input  logic [COORD_W-1:0]  tile_y,
  input  logic                pel_out,
  output logic [COORD_W-1:0]  pel_x,
  output logic [COORD_W-1:0]  pel_y,
  output logic                pel_clear,
  output logic                pel_reset,
  output logic                busy,
  output logic                eaten,
  output logic [SCORE_W-1:0]  score,
  output logic [REMAIN_W-1:0] remaining,
  output logic                level_clear
);

  logic [2:0]          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COORD_W-1:0]  tile_x_q, tile_x_d, tile_y_q, tile_y_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [REMAIN_W-1:0] remaining_q, remaining_d;
  logic                level_clear_q, level_clear_d;
  logic                eaten_q, eaten_d;

  logic [SCORE_W:0]    score_sum;
  logic [REMAIN_W-1:0] remaining_acc;

  assign score_sum     = {1'b0, score_q} + (SCORE_W+1)'(POINTS);
  assign remaining_acc = remaining_q + {{(REMAIN_W-1){1'b0}}, pel_out};

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    tile_x_d      = tile_x_q;
    tile_y_d      = tile_y_q;
    score_d       = score_q;
    remaining_d   = remaining_q;
    level_clear_d = level_clear_q;
    eaten_d       = 1'b0;
    if (level_start) begin
      state_d       = ST_RELOAD;
      level_clear_d = 1'b0;
    end else begin
      case (state_q)
        ST_RELOAD: begin
          addr_d        = '0;
          remaining_d   = '0;
          level_clear_d = 1'b0;
          state_d       = ST_SCAN;
        end
        ST_SCAN: begin
          addr_d = addr_q + ADDR_W'(1);
          // Read data lags the address by one cycle, so the first cycle has nothing to add.
          if (addr_q != '0) remaining_d = remaining_acc;
          if (addr_q == '1) state_d = ST_SCAN_TAIL;
        end
        ST_SCAN_TAIL: begin
          remaining_d   = remaining_acc;
          level_clear_d = (remaining_acc == '0);
          state_d       = ST_READY;
        end
        ST_READY: begin
          if (tile_valid) begin
            tile_x_d = tile_x;
            tile_y_d = tile_y;
            state_d  = ST_PROBE;
          end
        end
        ST_PROBE: state_d = ST_CHECK;
        ST_CHECK: begin
          if (pel_out) begin
            eaten_d = 1'b1;
            state_d = ST_CLEAR;
          end else begin
            state_d = ST_READY;
          end
        end
        ST_CLEAR: begin
          score_d       = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          remaining_d   = (remaining_q != '0) ? remaining_q - REMAIN_W'(1) : '0;
          level_clear_d = (remaining_q <= REMAIN_W'(1));
          state_d       = ST_READY;
        end
        default: state_d = ST_RELOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RELOAD;
      addr_q        <= '0;
      tile_x_q      <= '0;
      tile_y_q      <= '0;
      score_q       <= '0;
      remaining_q   <= '0;
      level_clear_q <= 1'b0;
      eaten_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      tile_x_q      <= tile_x_d;
      tile_y_q      <= tile_y_d;
      score_q       <= score_d;
      remaining_q   <= remaining_d;
      level_clear_q <= level_clear_d;
      eaten_q       <= eaten_d;
    end
  end

  always_comb begin
    pel_x = '0;
    pel_y = '0;
    case (state_q)
      ST_SCAN: begin
        pel_x = addr_q[COORD_W-1:0];
        pel_y = addr_q[ADDR_W-1:COORD_W];
      end
      ST_PROBE, ST_CHECK, ST_CLEAR: begin
        pel_x = tile_x_q;
        pel_y = tile_y_q;
      end
      default: ;
    endcase
  end

  assign pel_reset   = (state_q == ST_RELOAD);
  assign pel_clear   = (state_q == ST_CLEAR);
  assign busy        = (state_q != ST_READY);
  assign eaten       = eaten_q;
  assign score       = score_q;
  assign remaining   = remaining_q;
  assign level_clear = level_clear_q;

endmodule
`default_nettype wire

// File: tb/tb_pellet_eater.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pellet_eater: scoreboard bench with pellet memory models for a      |
// | 16-bit-score and an 8-bit-score instance.                              |
// | Rev 1.0  - initial release                                             |
// +------------------------------------------------------------------------+
module tb_pellet_eater;
  import pellet_pkg::*;

  localparam int NCELL = MAP_W * MAP_H;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic level_start = 1'b0;
  logic tile_valid = 1'b0;
  logic [4:0] tile_x = '0;
  logic [4:0] tile_y = '0;

  logic        pel_out, pel_clear, pel_reset, busy, eaten, level_clear;
  logic [4:0]  pel_x, pel_y;
  logic [15:0] score;
  logic [10:0] remaining;

  logic        pel_out8, pel_clear8, pel_reset8, busy8, eaten8, level_clear8;
  logic [4:0]  pel_x8, pel_y8;
  logic [7:0]  score8;
  logic [10:0] remaining8;

  logic [NCELL-1:0] mem_a, mem_b;

  always #5 clk = ~clk;

  pellet_eater #(.POINTS(10), .SCORE_W(16)) dut (
    .clk(clk), .reset(reset), .level_start(level_start), .tile_valid(tile_valid),
    .tile_x(tile_x), .tile_y(tile_y), .pel_out(pel_out), .pel_x(pel_x), .pel_y(pel_y),
    .pel_clear(pel_clear), .pel_reset(pel_reset), .busy(busy), .eaten(eaten),
    .score(score), .remaining(remaining), .level_clear(level_clear)
  );

  pellet_eater #(.POINTS(10), .SCORE_W(8)) dut8 (
    .clk(clk), .reset(reset), .level_start(level_start), .tile_valid(tile_valid),
    .tile_x(tile_x), .tile_y(tile_y), .pel_out(pel_out8), .pel_x(pel_x8), .pel_y(pel_y8),
    .pel_clear(pel_clear8), .pel_reset(pel_reset8), .busy(busy8), .eaten(eaten8),
    .score(score8), .remaining(remaining8), .level_clear(level_clear8)
  );

  // Pellet memories: synchronous reload, registered read, clear on strobe.
  always_ff @(posedge clk) begin
    if (pel_reset) mem_a <= MAP_INIT;
    else if (pel_clear) mem_a[{pel_y, pel_x}] <= 1'b0;
    pel_out <= mem_a[{pel_y, pel_x}];
  end

  always_ff @(posedge clk) begin
    if (pel_reset8) mem_b <= MAP_INIT;
    else if (pel_clear8) mem_b[{pel_y8, pel_x8}] <= 1'b0;
    pel_out8 <= mem_b[{pel_y8, pel_x8}];
  end

  typedef struct {
    int          len;
    int          eats;
    int          reloads;
    logic [15:0] score;
    logic [7:0]  score8;
    logic [10:0] rem;
    logic        lclr;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: measures each busy run and checks it against the next expected result.
  int run_len = 0, run_eats = 0, run_reloads = 0, eat_pos = 0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      run_len = 0; run_eats = 0; run_reloads = 0; eat_pos = 0;
    end else if (busy) begin
      run_len++;
      if (eaten) begin run_eats++; eat_pos = run_len; end
      if (pel_reset) run_reloads++;
    end else if (run_len > 0) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_busy_run", run_len, 0);
      end else begin
        e = sb_q.pop_front();
        chk("busy_len", run_len, e.len);
        chk("eaten_count", run_eats, e.eats);
        if (e.eats > 0) chk("eaten_cycle", eat_pos, 3);
        chk("pel_reset_cycles", run_reloads, e.reloads);
        chk("score", score, e.score);
        chk("score8", score8, e.score8);
        chk("remaining", remaining, e.rem);
        chk("level_clear", level_clear, e.lclr);
      end
      run_len = 0; run_eats = 0; run_reloads = 0; eat_pos = 0;
    end
  end

  // Reference model state
  logic [NCELL-1:0] model_map;
  logic [15:0]      m_score = '0;
  logic [7:0]       m_score8 = '0;
  logic [10:0]      m_rem = '0;
  logic             m_lclr = 1'b0;
  int               full_cnt;

  function automatic int popcount(input logic [NCELL-1:0] v);
    int c = 0;
    for (int i = 0; i < NCELL; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic model_reload(input int len);
    exp_t e;
    model_map = MAP_INIT;
    m_rem     = 11'(full_cnt);
    m_lclr    = (full_cnt == 0);
    e = '{len, 0, 1, m_score, m_score8, m_rem, m_lclr};
    sb_q.push_back(e);
  endtask

  task automatic wait_ready(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (busy === 1'b0) return;
    end
    chk("ready_timeout", busy, 0);
  endtask

  task automatic probe(input int x, input int y, input bit extra, input bit abort_it);
    exp_t e;
    int   idx;
    idx = y * MAP_W + x;
    wait_ready(2000);
    @(posedge clk); #1;
    tile_x = 5'(x); tile_y = 5'(y); tile_valid = 1'b1;
    if (abort_it) begin
      model_reload(1027);
    end else begin
      if (model_map[idx]) begin
        model_map[idx] = 1'b0;
        m_score  = (m_score > 16'(65535 - 10)) ? 16'hFFFF : m_score + 16'd10;
        m_score8 = (m_score8 > 8'(255 - 10)) ? 8'hFF : m_score8 + 8'd10;
        m_rem    = m_rem - 11'd1;
        m_lclr   = (m_rem == 0);
        e = '{3, 1, 0, m_score, m_score8, m_rem, m_lclr};
      end else begin
        e = '{2, 0, 0, m_score, m_score8, m_rem, m_lclr};
      end
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    if (extra) begin
      tile_x = 5'(x + 2); tile_y = 5'(y + 2);
    end else begin
      tile_valid = 1'b0;
    end
    if (abort_it) level_start = 1'b1;
    @(posedge clk); #1;
    tile_valid = 1'b0; level_start = 1'b0;
    wait_ready(2000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCELL-1:0] img;
    img = MAP_INIT;
    full_cnt = popcount(img);
    model_map = img;

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_pel_reset", pel_reset, 1);
    chk("rst_pel_clear", pel_clear, 0);
    chk("rst_pel_x", pel_x, 0);
    chk("rst_pel_y", pel_y, 0);
    chk("rst_score", score, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_level_clear", level_clear, 0);
    chk("rst_eaten", eaten, 0);
    chk("rst_score8", score8, 0);

    model_reload(1026);
    @(posedge clk); #1 reset = 1'b1;

    // Strobe during the scan must be dropped.
    repeat (100) @(posedge clk);
    #1 tile_x = 5'd2; tile_y = 5'd2; tile_valid = 1'b1;
    @(posedge clk); #1 tile_valid = 1'b0;
    wait_ready(2000);

    probe(2, 2, 1'b0, 1'b0);
    chk("mem_cleared_2_2", mem_a[2*MAP_W+2], 0);
    probe(2, 2, 1'b0, 1'b0);
    probe(0, 0, 1'b0, 1'b0);
    probe(4, 4, 1'b1, 1'b0);
    chk("mem_kept_6_6", mem_a[6*MAP_W+6], 1);
    probe(6, 6, 1'b0, 1'b1);
    chk("mem_restored_2_2", mem_a[2*MAP_W+2], 1);

    for (int i = 0; i < NCELL; i++) begin
      if (img[i]) probe(i % MAP_W, i / MAP_W, 1'b0, 1'b0);
    end

    // level_start and tile_valid together in READY: level_start wins.
    wait_ready(2000);
    @(posedge clk); #1;
    level_start = 1'b1; tile_valid = 1'b1; tile_x = 5'd8; tile_y = 5'd8;
    model_reload(1026);
    @(posedge clk); #1 level_start = 1'b0; tile_valid = 1'b0;
    @(negedge clk);
    chk("level_clear_drop", level_clear, 0);
    wait_ready(2000);
    probe(8, 8, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
